// File: rtl/load_store_unit.sv
// MIPS load/store stage: byte-lane alignment, variable-latency data-memory handshake
// and load extension, feeding the registered write-back outputs.
//
// state  | meaning
// S_IDLE | ready for a new instruction; non-memory and faulting ops complete here
// S_BUSY | data-memory request outstanding, waiting for dmem_ack
module load_store_unit #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    output logic        stall,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_write,
    input  logic [31:0] ex_inst,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_write_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_inst,
    output logic        addr_err,
    output logic [31:0] bad_vaddr
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic [0:0]  state;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [4:0]  write_reg_q;
    logic        reg_write_q;
    logic [31:0] inst_q;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        out_of_range;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        op_q_is_load;

    assign ex_ready = (state == S_IDLE);
    assign stall    = ~ex_ready;

    always_comb begin
        is_load      = (ex_op >= OP_LB) && (ex_op <= OP_LW);
        is_store     = (ex_op >= OP_SB) && (ex_op <= OP_SW);
        misaligned   = 1'b0;
        out_of_range = ({2'b00, ex_addr[31:2]} >= 32'(DMEM_WORDS));
        case (ex_op)
            OP_LH, OP_LHU, OP_SH: misaligned = ex_addr[0];
            OP_LW, OP_SW:         misaligned = (ex_addr[1:0] != 2'b00);
            default:              misaligned = 1'b0;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_op)
            OP_SB: begin
                st_be    = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            OP_SH: begin
                st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half      = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
        // stores fall to the default and complete with a zero result
        case (op_q)
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {24'h0, ld_byte};
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {16'h0, ld_half};
            OP_LW:   ld_ext = dmem_rdata;
            default: ld_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= 4'h0;
            off_q        <= 2'b00;
            write_reg_q  <= 5'h0;
            reg_write_q  <= 1'b0;
            inst_q       <= 32'h0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_be      <= 4'h0;
            dmem_addr    <= 32'h0;
            dmem_wdata   <= 32'h0;
            wb_valid     <= 1'b0;
            wb_result    <= 32'h0;
            wb_write_reg <= 5'h0;
            wb_reg_write <= 1'b0;
            wb_inst      <= 32'h0;
            addr_err     <= 1'b0;
            bad_vaddr    <= 32'h0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!(is_load || is_store)) begin
                            wb_valid     <= 1'b1;
                            wb_result    <= ex_result;
                            wb_reg_write <= ex_reg_write;
                            wb_write_reg <= ex_write_reg;
                            wb_inst      <= ex_inst;
                            addr_err     <= 1'b0;
                            bad_vaddr    <= 32'h0;
                        end else if (misaligned || out_of_range) begin
                            wb_valid     <= 1'b1;
                            wb_result    <= 32'h0;
                            wb_write_reg <= ex_write_reg;
                            wb_inst      <= ex_inst;
                            addr_err     <= 1'b1;
                            bad_vaddr    <= ex_addr;
                        end else begin
                            op_q        <= ex_op;
                            off_q       <= ex_addr[1:0];
                            write_reg_q <= ex_write_reg;
                            reg_write_q <= ex_reg_write;
                            inst_q      <= ex_inst;
                            dmem_req    <= 1'b1;
                            dmem_we     <= is_store;
                            dmem_be     <= st_be;
                            dmem_addr   <= {ex_addr[31:2], 2'b00};
                            dmem_wdata  <= st_wdata;
                            state       <= S_BUSY;
                        end
                    end
                end
                default: begin
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        state        <= S_IDLE;
                        wb_valid     <= 1'b1;
                        wb_result    <= ld_ext;
                        wb_reg_write <= op_q_is_load && reg_write_q;
                        wb_write_reg <= write_reg_q;
                        wb_inst      <= inst_q;
                        addr_err     <= 1'b0;
                        bad_vaddr    <= 32'h0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions checked against a transaction-level model of the stage.
module tb_load_store_unit;

    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        stall;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [31:0] ex_result;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write;
    logic [31:0] ex_inst;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_write_reg;
    logic        wb_reg_write;
    logic [31:0] wb_inst;
    logic        addr_err;
    logic [31:0] bad_vaddr;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_result;
    logic [31:0] last_inst;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_WORDS(DW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .stall(stall),
        .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_result(ex_result), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_inst(ex_inst),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_result(wb_result),
        .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
        .wb_inst(wb_inst), .addr_err(addr_err), .bad_vaddr(bad_vaddr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // access size in bytes; 0 means the op does not touch memory
    function automatic int unsigned size_of(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit is_err(input logic [3:0] op, input logic [31:0] addr);
        int unsigned sz = size_of(op);
        return (sz != 0) && (((addr % sz) != 0) || ((addr / 4) >= DW));
    endfunction

    function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] off = addr % 4;
        logic [31:0] b   = (rd >> (8 * off)) % 256;
        logic [31:0] h   = (rd >> (16 * (off / 2))) % 65536;
        case (op)
            4'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4'd2:    return b;
            4'd3:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] store_be(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            4'd6:    return 32'd1 << (addr % 4);
            4'd7:    return ((addr % 4) >= 2) ? 32'hC : 32'h3;
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
        case (op)
            4'd6:    return (wd % 256) * 32'h01010101;
            4'd7:    return (wd % 65536) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where wb_valid is high.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] res, input logic [4:0] wreg, input logic rwe,
                           input logic [31:0] inst, input logic [31:0] rd, input int lat);
        bit err;
        bit st;
        logic [31:0] exp_res;
        check("ready_before", ex_ready, 1);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wd; ex_result = res;
        ex_write_reg = wreg; ex_reg_write = rwe; ex_inst = inst;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 4'($urandom); ex_addr = $urandom; ex_result = $urandom;
        err = is_err(op, addr);
        st  = (op >= 4'd6) && (op <= 4'd8);
        if (size_of(op) == 0 || err) begin
            exp_res = err ? 32'h0 : res;
            check("single_wb_valid", wb_valid, 1);
            check("single_no_req", dmem_req, 0);
            check("single_addr_err", addr_err, err);
            check("single_bad_vaddr", bad_vaddr, err ? addr : 32'h0);
            check("single_reg_write", wb_reg_write, err ? 1'b0 : rwe);
            check("single_result", wb_result, exp_res);
            check("single_write_reg", wb_write_reg, wreg);
            check("single_inst", wb_inst, inst);
            check("single_ready", ex_ready, 1);
        end else begin
            exp_res = st ? 32'h0 : load_val(op, addr, rd);
            for (int i = 0; i <= lat; i++) begin
                check("req_high", dmem_req, 1);
                check("req_we", dmem_we, st);
                check("req_be", dmem_be, st ? store_be(op, addr) : 32'hF);
                check("req_addr", dmem_addr, addr & 32'hFFFFFFFC);
                if (st) check("req_wdata", dmem_wdata, store_data(op, wd));
                check("busy_stall", stall, 1);
                check("busy_ready", ex_ready, 0);
                check("busy_no_wb", wb_valid, 0);
                if (i == lat) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rd;
                end
                @(negedge clk);
            end
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            check("mem_wb_valid", wb_valid, 1);
            check("mem_result", wb_result, exp_res);
            check("mem_reg_write", wb_reg_write, st ? 1'b0 : rwe);
            check("mem_write_reg", wb_write_reg, wreg);
            check("mem_inst", wb_inst, inst);
            check("mem_addr_err", addr_err, 0);
            check("mem_req_dropped", dmem_req, 0);
            check("mem_ready", ex_ready, 1);
        end
        last_result = exp_res;
        last_inst = inst;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_wb_valid", wb_valid, 0);
        check("idle_reg_write", wb_reg_write, 0);
        check("idle_result_hold", wb_result, last_result);
        check("idle_inst_hold", wb_inst, last_inst);
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] addr;
        rst = 1'b1; ex_valid = 1'b0; ex_op = 4'h0; ex_addr = 32'h0; ex_wdata = 32'h0;
        ex_result = 32'h0; ex_write_reg = 5'h0; ex_reg_write = 1'b0; ex_inst = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_be", dmem_be, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_result", wb_result, 0);
        check("rst_wb_reg", wb_write_reg, 0);
        check("rst_wb_rw", wb_reg_write, 0);
        check("rst_wb_inst", wb_inst, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_bad_vaddr", bad_vaddr, 0);
        check("rst_ready", ex_ready, 1);
        check("rst_stall", stall, 0);
        rst = 1'b0;

        run_txn(4'd0, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1, 32'hC0DE0001, 32'h0, 0);
        idle_cycle();

        // load extension, ack latency 3
        run_txn(4'd1, 32'h103, 0, 0, 5'd4, 1'b1, 32'h11, 32'h80FF7F01, 2);
        check("lb_value", wb_result, 32'hFFFFFF80);
        run_txn(4'd2, 32'h103, 0, 0, 5'd5, 1'b1, 32'h12, 32'h80FF7F01, 2);
        check("lbu_value", wb_result, 32'h00000080);
        run_txn(4'd3, 32'h102, 0, 0, 5'd6, 1'b1, 32'h13, 32'h80FF7F01, 2);
        check("lh_value", wb_result, 32'hFFFF80FF);
        run_txn(4'd4, 32'h100, 0, 0, 5'd7, 1'b1, 32'h14, 32'h80FF7F01, 2);
        check("lhu_value", wb_result, 32'h00007F01);
        run_txn(4'd5, 32'h100, 0, 0, 5'd8, 1'b1, 32'h15, 32'h80FF7F01, 2);
        check("lw_value", wb_result, 32'h80FF7F01);

        // stores
        run_txn(4'd6, 32'h5, 32'hAABBCCDD, 0, 5'd9, 1'b1, 32'h16, 32'h0, 0);
        run_txn(4'd7, 32'h6, 32'hAABBCCDD, 0, 5'd9, 1'b1, 32'h17, 32'h0, 1);
        run_txn(4'd8, 32'h8, 32'hAABBCCDD, 0, 5'd9, 1'b1, 32'h18, 32'h0, 0);

        // faulting accesses
        run_txn(4'd5, 32'h102, 0, 32'h55, 5'd10, 1'b1, 32'h19, 32'h0, 0);
        run_txn(4'd7, 32'h1, 0, 32'h55, 5'd10, 1'b1, 32'h1A, 32'h0, 0);
        run_txn(4'd5, 32'h1000, 0, 32'h55, 5'd10, 1'b1, 32'h1B, 32'h0, 0);
        run_txn(4'd5, 32'hFFC, 0, 32'h55, 5'd10, 1'b1, 32'h1C, 32'hDEADBEEF, 0);

        // long stall, then a stray ack while idle
        run_txn(4'd8, 32'h40, 32'h01020304, 0, 5'd11, 1'b0, 32'h1D, 32'h0, 10);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("stray_no_wb", wb_valid, 0);
        check("stray_no_req", dmem_req, 0);
        check("stray_ready", ex_ready, 1);

        // reset while busy, with a simultaneous ack, then a late ack
        ex_valid = 1'b1; ex_op = 4'd5; ex_addr = 32'h20; ex_reg_write = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        check("rb_req", dmem_req, 1);
        rst = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rb_req_dropped", dmem_req, 0);
        check("rb_no_wb", wb_valid, 0);
        check("rb_ready", ex_ready, 1);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rb_late_ack_no_wb", wb_valid, 0);
        check("rb_late_ack_no_req", dmem_req, 0);
        last_result = 32'h0;
        last_inst = 32'h0;

        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = $urandom_range(0, 4400);
            if ($urandom_range(0, 1) == 1) addr = addr & ~((size_of(op) == 0) ? 32'h0 : size_of(op) - 1);
            run_txn(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                    $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
